// File: rtl/addsub_limb_sequencer.sv
// Multi-precision add/subtract: one LIMB_W-bit limb per cycle through a single carry slice.
// Optional carry/overflow flags are enabled with ADDSUB_SEQ_FLAGS_EN.
module addsub_limb_sequencer #(
  parameter int NLIMBS = 4,
  parameter int LIMB_W = 8
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op,
  input  logic [NLIMBS*LIMB_W-1:0] z,
  input  logic [NLIMBS*LIMB_W-1:0] x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLIMBS*LIMB_W-1:0] a,
`ifdef ADDSUB_SEQ_FLAGS_EN
  output logic                     cout,
  output logic                     ovf,
`endif
  output logic                     busy
);

  localparam int W  = NLIMBS * LIMB_W;
  localparam int CW = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // RUN   | one limb per edge, LSB limb first
  // DONE  | result held, waiting for out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            op_q;
  logic [W-1:0]    z_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    a_q;
  logic            out_valid_q;
  logic            busy_q;
  logic            in_ready_q;

  logic [LIMB_W-1:0] z_limb;
  logic [LIMB_W-1:0] x_limb;
  logic [LIMB_W-1:0] x_eff;
  logic [LIMB_W:0]   sum_d;
  logic              last_limb;

  assign z_limb    = z_q[cnt_q*LIMB_W +: LIMB_W];
  assign x_limb    = x_q[cnt_q*LIMB_W +: LIMB_W];
  assign x_eff     = op_q ? ~x_limb : x_limb;
  assign sum_d     = {1'b0, z_limb} + {1'b0, x_eff} + {{LIMB_W{1'b0}}, carry_q};
  assign last_limb = (cnt_q == CW'(NLIMBS - 1));

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic cout_q;
  logic ovf_q;
  logic msb_cin;

  // Carry into the top bit recovered from the sum bit and the two operand bits.
  assign msb_cin = z_limb[LIMB_W-1] ^ x_eff[LIMB_W-1] ^ sum_d[LIMB_W-1];
  assign cout    = cout_q;
  assign ovf     = ovf_q;
`endif

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_q        <= 1'b0;
      z_q         <= '0;
      x_q         <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ADDSUB_SEQ_FLAGS_EN
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            z_q        <= z;
            x_q        <= x;
            op_q       <= op;
            carry_q    <= op;
            cnt_q      <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          a_q[cnt_q*LIMB_W +: LIMB_W] <= sum_d[LIMB_W-1:0];
          carry_q <= sum_d[LIMB_W];
          if (last_limb) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
`ifdef ADDSUB_SEQ_FLAGS_EN
            cout_q      <= sum_d[LIMB_W];
            ovf_q       <= msb_cin ^ sum_d[LIMB_W];
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign a         = a_q;

endmodule

// File: tb/tb_addsub_limb_sequencer.sv
// Directed bench for addsub_limb_sequencer: 4-limb instance driven through a result scoreboard,
// plus a 1-limb instance. Flag outputs are checked when ADDSUB_SEQ_FLAGS_EN is defined.
module tb_addsub_limb_sequencer;

  localparam int W = 32;

  logic         CLK;
  logic         ASYNCRESETN;
  logic         in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [W-1:0] z, x, a;
  logic         s_in_valid, s_in_ready, s_op, s_out_valid, s_out_ready, s_busy;
  logic [7:0]   s_z, s_x, s_a;
`ifdef ADDSUB_SEQ_FLAGS_EN
  logic         cout, ovf, s_cout, s_ovf;
  logic         last_cout, last_ovf;
`endif

  addsub_limb_sequencer #(.NLIMBS(4), .LIMB_W(8)) u_dut4 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .z(z), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .a(a),
`ifdef ADDSUB_SEQ_FLAGS_EN
    .cout(cout), .ovf(ovf),
`endif
    .busy(busy)
  );

  addsub_limb_sequencer #(.NLIMBS(1), .LIMB_W(8)) u_dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .z(s_z), .x(s_x),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .a(s_a),
`ifdef ADDSUB_SEQ_FLAGS_EN
    .cout(s_cout), .ovf(s_ovf),
`endif
    .busy(s_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [W-1:0] sb[$];
  int          acc_cyc[$];
  int          rise_cyc = 0;
  logic        ov_prev = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic o, input logic [W-1:0] zz, input logic [W-1:0] xx);
    return o ? (zz - xx) : (zz + xx);
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    logic [W-1:0] exp;
    @(negedge CLK);
    if (in_valid && in_ready) acc_cyc.push_back(cyc + 1);
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_result", a, 'x);
      else begin
        exp = sb.pop_front();
        chk("sb_result", a, exp);
        chk("busy_at_handshake", {31'd0, busy}, 1);
`ifdef ADDSUB_SEQ_FLAGS_EN
        last_cout = cout;
        last_ovf  = ovf;
`endif
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic o, input logic [W-1:0] zz, input logic [W-1:0] xx);
    op = o; z = zz; x = xx; in_valid = 1'b1;
    sb.push_back(model(o, zz, xx));
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("result_timeout", sb.size(), 0);
  endtask

  initial begin
    int n;
    int nacc;
    ASYNCRESETN = 1'b0;
    in_valid = 1'b0; op = 1'b0; z = '0; x = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_op = 1'b0; s_z = '0; s_x = '0; s_out_ready = 1'b0;
    #22 ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;

    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_a", a, 0);

    // Add with ripple across a limb boundary
    out_ready = 1'b1;
    drive(1'b0, 32'h0000_00FF, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    chk("add_busy_after_accept", {31'd0, busy}, 1);
    chk("add_in_ready_run", {31'd0, in_ready}, 0);
    wait_result(n);
    chk("add_latency", rise_cyc - acc_cyc[acc_cyc.size()-1], 4);
    chk("add_out_valid_cleared", {31'd0, out_valid}, 0);
    chk("add_busy_cleared", {31'd0, busy}, 0);
    chk("add_in_ready_back", {31'd0, in_ready}, 1);

    // Subtract with full borrow chain
    drive(1'b1, 32'h0000_0000, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    wait_result(n);
`ifdef ADDSUB_SEQ_FLAGS_EN
    chk("sub_cout", {31'd0, last_cout}, 0);
    chk("sub_ovf", {31'd0, last_ovf}, 0);
`endif

    // Backpressure: result held while out_ready is low, new requests ignored
    out_ready = 1'b0;
    drive(1'b0, 32'h1234_5678, 32'h1111_1111);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("bp_out_valid_rise", {31'd0, out_valid}, 1);
    nacc = acc_cyc.size();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = 1'b1; z = 32'hDEAD_BEEF; x = 32'h0BAD_F00D;
      step();
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
      chk("bp_hold_a", a, 32'h2345_6789);
      chk("bp_in_ready_low", {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_result(n);
    chk("bp_handshake_cycles", n, 1);
    chk("bp_no_extra_accepts", acc_cyc.size(), nacc);
    chk("bp_out_valid_cleared", {31'd0, out_valid}, 0);

    // Reset in the middle of RUN
    drive(1'b0, 32'h1234_5678, 32'h1111_1111);
    step();
    in_valid = 1'b0;
    step();
    step();
    ASYNCRESETN = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_a", a, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    sb.delete();
    #2 ASYNCRESETN = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    drive(1'b0, 32'd1, 32'd2);
    step();
    in_valid = 1'b0;
    wait_result(n);

    // Back-to-back with in_valid held high
    acc_cyc.delete();
    drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    drive(1'b1, 32'h8000_0000, 32'h0000_0001);
    n = 0;
    while (acc_cyc.size() < 2 && n < 30) begin step(); n++; end
    in_valid = 1'b0;
    chk("b2b_accept_count", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 6);
    wait_result(n);

    // Single-limb instance
    s_out_ready = 1'b1;
    s_op = 1'b1; s_z = 8'h10; s_x = 8'h01; s_in_valid = 1'b1;
    @(posedge CLK); #1;
    s_in_valid = 1'b0;
    chk("n1_busy", {31'd0, s_busy}, 1);
    @(posedge CLK); #1;
    chk("n1_sub_valid", {31'd0, s_out_valid}, 1);
    chk("n1_sub_a", {24'd0, s_a}, 32'h0F);
    @(posedge CLK); #1;
    chk("n1_valid_cleared", {31'd0, s_out_valid}, 0);
    s_op = 1'b0; s_z = 8'h7F; s_x = 8'h01; s_in_valid = 1'b1;
    @(posedge CLK); #1;
    s_in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("n1_add_valid", {31'd0, s_out_valid}, 1);
    chk("n1_add_a", {24'd0, s_a}, 32'h80);
`ifdef ADDSUB_SEQ_FLAGS_EN
    chk("n1_ovf", {31'd0, s_ovf}, 1);
    chk("n1_cout", {31'd0, s_cout}, 0);
`endif
    @(posedge CLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
